// File: rtl/run_monitor_if.sv
// run_monitor_if: harness-side signal bundle between run_monitor and the
// design under fault injection. The slave modport is the monitor's view,
// the master modport is the view of whatever drives toggle_in and consumes
// the verdict.
interface run_monitor_if #(
    parameter int CNT_W = 8
);
    logic             toggle_in;
    logic             dut_rst;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_err_cycle;

    modport master (
        output toggle_in,
        input  dut_rst,
        input  done,
        input  pass,
        input  err_cnt,
        input  first_err_cycle
    );

    modport slave (
        input  toggle_in,
        output dut_rst,
        output done,
        output pass,
        output err_cnt,
        output first_err_cycle
    );
endinterface

// File: rtl/run_monitor.sv
// run_monitor: generates the reset sequence for a design under fault
// injection, then checks for RUN_CYCLES cycles that a free-running toggle
// flop from the design inverts every cycle. Reports done, pass, a
// saturating mismatch count and the run index of the first mismatch.
//
// Optional build macro RUN_MONITOR_FINISH_EN: when defined, the block prints
// its verdict and ends simulation on the edge that enters DONE. Register
// behaviour is the same with or without it.
module run_monitor #(
    parameter int RST_CYCLES = 4,
    parameter int RUN_CYCLES = 8,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    run_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

    // Increment that sticks at all-ones so a heavily failing run never
    // wraps back to a count that looks clean.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == CNT_MAX) begin
            res = CNT_MAX;
        end else begin
            res = val + CNT_ONE;
        end
        return res;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] rst_cnt_r;
    logic [CNT_W-1:0] rst_cnt_nxt_s;
    logic [CNT_W-1:0] run_cnt_r;
    logic [CNT_W-1:0] run_cnt_nxt_s;
    logic             prev_r;
    logic             prev_nxt_s;
    logic             dut_rst_r;
    logic             dut_rst_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             pass_r;
    logic             pass_nxt_s;
    logic [CNT_W-1:0] err_cnt_r;
    logic [CNT_W-1:0] err_cnt_nxt_s;
    logic [CNT_W-1:0] first_err_r;
    logic [CNT_W-1:0] first_err_nxt_s;
    logic             mismatch_s;

    // A healthy toggle differs from the previous sample; equality is a miss.
    assign mismatch_s = (mon.toggle_in == prev_r);

    // State and datapath registers, all returned to reset values by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RESET;
            rst_cnt_r   <= CNT_ZERO;
            run_cnt_r   <= CNT_ZERO;
            prev_r      <= 1'b0;
            dut_rst_r   <= 1'b1;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_cnt_r   <= CNT_ZERO;
            first_err_r <= CNT_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            rst_cnt_r   <= rst_cnt_nxt_s;
            run_cnt_r   <= run_cnt_nxt_s;
            prev_r      <= prev_nxt_s;
            dut_rst_r   <= dut_rst_nxt_s;
            done_r      <= done_nxt_s;
            pass_r      <= pass_nxt_s;
            err_cnt_r   <= err_cnt_nxt_s;
            first_err_r <= first_err_nxt_s;
        end
    end

    // Next-state decode: reset hold, one arming cycle, fixed-length run, done.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RESET: begin
                if (rst_cnt_r == RST_LAST) begin
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_RESET;
                end
            end
            ST_ARM: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (run_cnt_r == RUN_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_RESET;
            end
        endcase
    end

    // Next values of counters and registered outputs for the current state.
    always_comb begin
        rst_cnt_nxt_s   = rst_cnt_r;
        run_cnt_nxt_s   = run_cnt_r;
        prev_nxt_s      = prev_r;
        dut_rst_nxt_s   = dut_rst_r;
        done_nxt_s      = done_r;
        pass_nxt_s      = pass_r;
        err_cnt_nxt_s   = err_cnt_r;
        first_err_nxt_s = first_err_r;
        case (state_r)
            ST_RESET: begin
                // dut_rst drops on the same edge the FSM moves to ARM.
                if (rst_cnt_r == RST_LAST) begin
                    rst_cnt_nxt_s = rst_cnt_r;
                    dut_rst_nxt_s = 1'b0;
                end else begin
                    rst_cnt_nxt_s = rst_cnt_r + CNT_ONE;
                    dut_rst_nxt_s = 1'b1;
                end
            end
            ST_ARM: begin
                // First post-reset value of the design seeds the comparison.
                prev_nxt_s    = mon.toggle_in;
                run_cnt_nxt_s = CNT_ZERO;
                dut_rst_nxt_s = 1'b0;
            end
            ST_RUN: begin
                dut_rst_nxt_s = 1'b0;
                if (mismatch_s) begin
                    err_cnt_nxt_s = sat_inc(err_cnt_r);
                    if (err_cnt_r == CNT_ZERO) begin
                        first_err_nxt_s = run_cnt_r;
                    end else begin
                        first_err_nxt_s = first_err_r;
                    end
                end else begin
                    err_cnt_nxt_s   = err_cnt_r;
                    first_err_nxt_s = first_err_r;
                end
                // Track the sampled value so a phase slip counts only once.
                prev_nxt_s    = mon.toggle_in;
                run_cnt_nxt_s = run_cnt_r + CNT_ONE;
                if (run_cnt_r == RUN_LAST) begin
                    done_nxt_s = 1'b1;
                    pass_nxt_s = (err_cnt_r == CNT_ZERO) && !mismatch_s;
                end else begin
                    done_nxt_s = 1'b0;
                    pass_nxt_s = 1'b0;
                end
            end
            ST_DONE: begin
                dut_rst_nxt_s = 1'b0;
            end
            default: begin
                dut_rst_nxt_s = 1'b1;
                done_nxt_s    = 1'b0;
                pass_nxt_s    = 1'b0;
            end
        endcase
    end

`ifdef RUN_MONITOR_FINISH_EN
    // Print the verdict and stop simulation on the edge that enters DONE.
    always @(posedge clk) begin
        if (!rst && (state_r == ST_RUN) && (state_nxt_s == ST_DONE)) begin
            $display("run_monitor: %s err_cnt=%0d",
                     pass_nxt_s ? "pass" : "fail", err_cnt_nxt_s);
            $finish;
        end
    end
`else
    // No system tasks: DONE holds until rst and the harness decides when to stop.
`endif

    assign mon.dut_rst         = dut_rst_r;
    assign mon.done            = done_r;
    assign mon.pass            = pass_r;
    assign mon.err_cnt         = err_cnt_r;
    assign mon.first_err_cycle = first_err_r;

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed bench for run_monitor. Two instances share rst
// and the toggle stimulus: A uses default parameters, B uses CNT_W=2 and
// RUN_CYCLES=3 so its counter saturates on a held toggle.
module tb_run_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tog = 1'b0;

    always #5 clk = ~clk;

    run_monitor_if #(.CNT_W(8)) ifa ();
    run_monitor_if #(.CNT_W(2)) ifb ();

    assign ifa.toggle_in = tog;
    assign ifb.toggle_in = tog;

    run_monitor #(.RST_CYCLES(4), .RUN_CYCLES(8), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .mon (ifa)
    );

    run_monitor #(.RST_CYCLES(4), .RUN_CYCLES(3), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .mon (ifb)
    );

    int   checks   = 0;
    int   failures = 0;
    bit   check_en = 1'b0;
    int   n        = 0;        // edges since rst was last sampled high
    logic hist [0:255];        // toggle value sampled at edge n

    // Edge counter and toggle history as the monitor sees them.
    always @(posedge clk) begin
        if (rst) begin
            n <= 0;
        end else if (n < 250) begin
            hist[n + 1] <= tog;
            n <= n + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs after edge n: reset lasts rc edges, ARM is edge rc+1,
    // run index i is edge rc+2+i and compares against the sample one edge earlier.
    function automatic void model(input int rc, input int rn, input int mx,
                                  output int e_rst, output int e_done,
                                  output int e_pass, output int e_cnt,
                                  output int e_first);
        e_cnt   = 0;
        e_first = 0;
        e_rst   = (n < rc) ? 1 : 0;
        e_done  = (n >= rc + 1 + rn) ? 1 : 0;
        for (int i = 0; i < rn; i++) begin
            if (rc + 2 + i <= n) begin
                if (hist[rc + 2 + i] === hist[rc + 1 + i]) begin
                    if (e_cnt == 0) e_first = i;
                    if (e_cnt < mx) e_cnt = e_cnt + 1;
                end
            end
        end
        e_pass = (e_done == 1 && e_cnt == 0) ? 1 : 0;
    endfunction

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int r, d, p, c, f;
        if (check_en) begin
            model(4, 8, 255, r, d, p, c, f);
            chk("a_dut_rst", int'(ifa.dut_rst), r);
            chk("a_done",    int'(ifa.done), d);
            chk("a_pass",    int'(ifa.pass), p);
            chk("a_err_cnt", int'(ifa.err_cnt), c);
            if (c != 0) chk("a_first_err", int'(ifa.first_err_cycle), f);
            model(4, 3, 3, r, d, p, c, f);
            chk("b_dut_rst", int'(ifb.dut_rst), r);
            chk("b_done",    int'(ifb.done), d);
            chk("b_pass",    int'(ifb.pass), p);
            chk("b_err_cnt", int'(ifb.err_cnt), c);
            if (c != 0) chk("b_first_err", int'(ifb.first_err_cycle), f);
        end
    end

    task automatic cyc(input logic r, input logic t);
        @(negedge clk);
        rst = r;
        tog = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles.
        cyc(1'b1, 1'b0);
        check_en = 1'b1;
        cyc(1'b1, 1'b0);
        chk("rst_dut_rst", int'(ifa.dut_rst), 1);
        chk("rst_done",    int'(ifa.done), 0);
        chk("rst_pass",    int'(ifa.pass), 0);
        chk("rst_err_cnt", int'(ifa.err_cnt), 0);
        chk("rst_first",   int'(ifa.first_err_cycle), 0);

        // Clean alternating toggle.
        for (int k = 1; k <= 13; k++) begin
            cyc(1'b0, (k % 2) == 1);
            if (k == 4)  chk("clean_dut_rst_r4", int'(ifa.dut_rst), 1 - 1);
            if (k == 3)  chk("clean_dut_rst_r3", int'(ifa.dut_rst), 1);
            if (k == 12) chk("clean_done_r12", int'(ifa.done), 0);
        end
        chk("clean_done", int'(ifa.done), 1);
        chk("clean_pass", int'(ifa.pass), 1);
        chk("clean_err",  int'(ifa.err_cnt), 0);
        chk("clean_b_pass", int'(ifb.pass), 1);

        // Toggle stuck at 0: every run edge repeats the previous sample.
        cyc(1'b1, 1'b0);
        for (int k = 1; k <= 13; k++) cyc(1'b0, 1'b0);
        chk("stuck_err",   int'(ifa.err_cnt), 8);
        chk("stuck_first", int'(ifa.first_err_cycle), 0);
        chk("stuck_pass",  int'(ifa.pass), 0);
        chk("sat_b_err",   int'(ifb.err_cnt), 3);
        chk("sat_b_pass",  int'(ifb.pass), 0);

        // Single phase slip at run index 3 (edge 9 repeats edge 8).
        cyc(1'b1, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            if (k < 9) cyc(1'b0, (k % 2) == 1);
            else       cyc(1'b0, ((k - 1) % 2) == 1);
        end
        chk("slip_err",   int'(ifa.err_cnt), 1);
        chk("slip_first", int'(ifa.first_err_cycle), 3);
        chk("slip_pass",  int'(ifa.pass), 0);
        chk("slip_done",  int'(ifa.done), 1);
        chk("slip_b_pass", int'(ifb.pass), 1);

        // Reset at run index 5 after errors, then a clean rerun.
        cyc(1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) cyc(1'b0, 1'b0);
        chk("mid_err_before", int'(ifa.err_cnt), 5);
        cyc(1'b1, 1'b0);
        chk("mid_err",     int'(ifa.err_cnt), 0);
        chk("mid_done",    int'(ifa.done), 0);
        chk("mid_dut_rst", int'(ifa.dut_rst), 1);
        for (int k = 1; k <= 13; k++) cyc(1'b0, (k % 2) == 1);
        chk("rerun_done", int'(ifa.done), 1);
        chk("rerun_pass", int'(ifa.pass), 1);

        // DONE holds for 20 more cycles whatever toggle does.
        for (int j = 0; j < 20; j++) cyc(1'b0, 1'($urandom_range(1, 0)));
        chk("hold_done", int'(ifa.done), 1);
        chk("hold_pass", int'(ifa.pass), 1);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
